// File: rtl/instr_fetch.sv
// instr_fetch: PC register plus single-outstanding fetch to instruction
// memory, presenting each word and its PC to decode over valid/ready.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_req/mem_addr/mem_ready      fetch request handshake (out/out/in)
//   mem_rvalid/mem_rdata            fetch response (in)
//   instr_valid/instr/instr_op      decoded-side word, opcode bits [6:0]
//   instr_pc/instr_ready            PC of instr, decode acceptance (in)
//   redirect/redirect_pc            taken branch/jump and its target (in)
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  instr_op,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] tgt;
    logic        stale;
    logic        stale_d;
    logic        cap;

    assign tgt = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d = state;
        pc_d    = pc;
        stale_d = stale;
        cap     = 1'b0;
        unique case (state)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = tgt;
            end
            REQ: begin
                if (redirect) pc_d = tgt;
                if (mem_ready) begin
                    state_d = WAIT;
                    // the accepted fetch belongs to the old path
                    if (redirect) stale_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = tgt;
                    stale_d = 1'b1;
                end
                if (mem_rvalid) begin
                    if (stale || redirect) begin
                        stale_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (instr_ready) begin
                    pc_d    = pc + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= PC0;
            stale    <= 1'b0;
            instr    <= NOP;
            instr_pc <= 32'h0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            stale <= stale_d;
            if (cap) begin
                instr    <= mem_rdata;
                instr_pc <= pc;
            end
        end
    end

    assign mem_req     = (state == REQ);
    assign mem_addr    = pc;
    assign instr_valid = (state == HOLD);
    assign instr_op    = instr[6:0];

endmodule
